// File: rtl/fp_addsub_seq_if.sv
// rtl/fp_addsub_seq_if.sv - operand/result handshake bundle for fp_addsub_seq
//
// Purpose: groups the operand-in and result-out handshakes of the binary32
// add/subtract sequencer.
// Signals:
//   in_valid/in_ready   operand pair handshake
//   a, b, op            operands (binary32) and operation (0 = a+b, 1 = a-b)
//   out_valid/out_ready result handshake
//   result              packed binary32 result
//   flag_ovf/unf/nx/inv overflow, underflow (flush), inexact, invalid
// Modports: master = producer/consumer side, slave = sequencer side.
interface fp_addsub_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_nx;
  logic        flag_inv;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_nx, flag_inv
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flag_ovf, flag_unf, flag_nx, flag_inv
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle IEEE-754 binary32 add/subtract sequencer
//
// Purpose: accepts an operand pair, runs it through
// UNPACK -> ALIGN -> ADD -> NORM -> ROUND and presents a packed result with
// exception flags. Subnormal inputs are flushed to zero, rounding is
// round-to-nearest-even. Contains the single shared 28-bit add/sub unit.
// Ports (fp_addsub_seq):
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    fp_addsub_seq_if.slave handshake bundle (operands, result, flags)
// Ports (adder):
//   A, B   in  28-bit magnitudes, A_S in: 0 = A+B, 1 = A-B
//   S      out 28-bit sum/difference, Co out carry (no-borrow on subtract)

module adder (
  input  logic [27:0] A,
  input  logic [27:0] B,
  input  logic        A_S,
  output logic [27:0] S,
  output logic        Co
);
  // Subtract as A + ~B + 1.
  assign {Co, S} = {1'b0, A} + {1'b0, B ^ {28{A_S}}} + {28'b0, A_S};
endmodule

module fp_addsub_seq (
  input  logic            clk,
  input  logic            rst_n,
  fp_addsub_seq_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sb_q, sb_d;       // effective sign of B
  logic               sign_q, sign_d;   // result sign (larger operand)
  logic               sub_q, sub_d;     // effective subtraction
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [27:0]        ma_q, ma_d, mb_q, mb_d, s_q, s_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [31:0]        res_q, res_d;
  logic [3:0]         flg_q, flg_d;     // {ovf, unf, nx, inv}

  // Operand decode
  logic [7:0]  ea_in, eb_in;
  logic [22:0] fa_in, fb_in;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;

  assign ea_in  = a_q[30:23];
  assign eb_in  = b_q[30:23];
  assign fa_in  = a_q[22:0];
  assign fb_in  = b_q[22:0];
  assign a_zero = (ea_in == 8'd0);
  assign b_zero = (eb_in == 8'd0);
  assign a_inf  = (ea_in == 8'hFF) && (fa_in == 23'd0);
  assign b_inf  = (eb_in == 8'hFF) && (fb_in == 23'd0);
  assign a_nan  = (ea_in == 8'hFF) && (fa_in != 23'd0);
  assign b_nan  = (eb_in == 8'hFF) && (fb_in != 23'd0);
  // Exponent-then-fraction magnitude compare is a plain compare of bits 30:0.
  assign a_ge_b = (a_q[30:0] >= b_q[30:0]);

  // Alignment shifter with sticky collection
  logic [8:0]  d;
  logic [27:0] mb_shift, mb_lost;
  assign d        = {1'b0, ea_q} - {1'b0, eb_q};
  assign mb_shift = mb_q >> d;
  assign mb_lost  = mb_q & ~(28'hFFF_FFFF << d);

  // Shared add/sub unit
  logic [27:0] add_s;
  logic        add_co;
  adder u_adder (
    .A   (ma_q),
    .B   (mb_q),
    .A_S (sub_q),
    .S   (add_s),
    .Co  (add_co)
  );

  // Round-to-nearest-even on the normalized mantissa (bit 3 is the LSB kept)
  logic               rnd_up;
  logic [24:0]        mant_r;
  logic [22:0]        frac_r;
  logic signed [9:0]  exp_r;
  assign rnd_up = s_q[2] & (s_q[1] | s_q[0] | s_q[3]);
  assign mant_r = {1'b0, s_q[26:3]} + {24'd0, rnd_up};
  assign frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
  assign exp_r  = mant_r[24] ? exp_q + 10'sd1 : exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sb_q    <= 1'b0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      s_q     <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sb_q    <= sb_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      s_q     <= s_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sb_d    = sb_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    s_d     = s_q;
    exp_d   = exp_q;
    res_d   = res_q;
    flg_d   = flg_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sb_d    = bus.b[31] ^ bus.op;
          flg_d   = 4'b0000;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        state_d = S_DONE;
        if (a_nan || b_nan) begin
          res_d = QNAN;
          flg_d = 4'b0001;
        end else if (a_inf && b_inf) begin
          if (a_q[31] != sb_q) begin
            res_d = QNAN;
            flg_d = 4'b0001;
          end else begin
            res_d = a_q;
          end
        end else if (a_inf) begin
          res_d = a_q;
        end else if (b_inf) begin
          res_d = {sb_q, b_q[30:0]};
        end else if (a_zero && b_zero) begin
          res_d = {a_q[31] & sb_q, 31'd0};
        end else if (a_zero) begin
          res_d = {sb_q, b_q[30:0]};
        end else if (b_zero) begin
          res_d = a_q;
        end else begin
          state_d = S_ALIGN;
          sub_d   = a_q[31] ^ sb_q;
          if (a_ge_b) begin
            ea_d   = ea_in;
            eb_d   = eb_in;
            ma_d   = {2'b01, fa_in, 3'b000};
            mb_d   = {2'b01, fb_in, 3'b000};
            sign_d = a_q[31];
            exp_d  = $signed({2'b00, ea_in});
          end else begin
            ea_d   = eb_in;
            eb_d   = ea_in;
            ma_d   = {2'b01, fb_in, 3'b000};
            mb_d   = {2'b01, fa_in, 3'b000};
            sign_d = sb_q;
            exp_d  = $signed({2'b00, eb_in});
          end
        end
      end

      S_ALIGN: begin
        state_d = S_ADD;
        if (d >= 9'd27) begin
          mb_d = (mb_q != 28'd0) ? 28'd1 : 28'd0;
        end else begin
          mb_d = {mb_shift[27:1], mb_shift[0] | (|mb_lost)};
        end
      end

      S_ADD: begin
        s_d = add_s;
        // Exact cancellation: with |A| >= |B| the subtract never borrows.
        if (sub_q && add_co && (add_s == 28'd0)) begin
          res_d   = 32'd0;
          state_d = S_DONE;
        end else begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (s_q[27]) begin
          s_d     = {1'b0, s_q[27:2], s_q[1] | s_q[0]};
          exp_d   = exp_q + 10'sd1;
          state_d = S_ROUND;
        end else if (!s_q[26]) begin
          // Another left shift would take the exponent to 0: flush.
          if (exp_q <= 10'sd1) begin
            res_d   = {sign_q, 31'd0};
            flg_d   = 4'b0110;
            state_d = S_DONE;
          end else begin
            s_d   = {s_q[26:0], 1'b0};
            exp_d = exp_q - 10'sd1;
          end
        end else begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        state_d = S_DONE;
        if (exp_r >= 10'sd255) begin
          res_d = {sign_q, 8'hFF, 23'd0};
          flg_d = 4'b1010;
        end else begin
          res_d = {sign_q, exp_r[7:0], frac_r};
          flg_d = {2'b00, |s_q[2:0], 1'b0};
        end
      end

      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.flag_ovf  = flg_q[3];
  assign bus.flag_unf  = flg_q[2];
  assign bus.flag_nx   = flg_q[1];
  assign bus.flag_inv  = flg_q[0];
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb/tb_fp_addsub_seq.sv - directed-vector self-checking bench for fp_addsub_seq
module tb_fp_addsub_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fp_addsub_seq_if ifc ();

  fp_addsub_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  fl;   // {ovf, unf, nx, inv}
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {ifc.flag_ovf, ifc.flag_unf, ifc.flag_nx, ifc.flag_inv};
  endfunction

  task automatic run_vec(input int idx, input int hold);
    vec_t        v;
    int          lat;
    logic [31:0] res0;
    v = vecs[idx];
    @(negedge clk);
    check_eq($sformatf("v%0d_in_ready_pre", idx), {31'd0, ifc.in_ready}, 32'd1);
    ifc.a        = v.a;
    ifc.b        = v.b;
    ifc.op       = v.op;
    ifc.in_valid = 1'b1;
    ifc.out_ready = 1'b0;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    lat = 0;
    while (!ifc.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq($sformatf("v%0d_out_valid", idx), {31'd0, ifc.out_valid}, 32'd1);
    check_eq($sformatf("v%0d_latency", idx), lat, v.lat);
    check_eq($sformatf("v%0d_result", idx), ifc.result, v.res);
    check_eq($sformatf("v%0d_flags", idx), {28'd0, flags_now()}, {28'd0, v.fl});
    res0 = ifc.result;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("v%0d_hold%0d_result", idx, h), ifc.result, res0);
      check_eq($sformatf("v%0d_hold%0d_flags", idx, h), {28'd0, flags_now()}, {28'd0, v.fl});
      check_eq($sformatf("v%0d_hold%0d_in_ready", idx, h), {31'd0, ifc.in_ready}, 32'd0);
      check_eq($sformatf("v%0d_hold%0d_out_valid", idx, h), {31'd0, ifc.out_valid}, 32'd1);
    end
    @(negedge clk);
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    check_eq($sformatf("v%0d_in_ready_post", idx), {31'd0, ifc.in_ready}, 32'd1);
    check_eq($sformatf("v%0d_out_valid_post", idx), {31'd0, ifc.out_valid}, 32'd0);
  endtask

  initial begin
    logic saw_valid;
    n_checks = 0;
    n_errors = 0;
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.op        = 1'b0;
    ifc.out_ready = 1'b0;
    rst_n         = 1'b0;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 5};
    vecs[1]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010, 5};
    vecs[2]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0010, 5};
    vecs[3]  = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000, 28};
    vecs[4]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 3};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1010, 5};
    vecs[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0001, 1};
    vecs[7]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0001, 1};
    vecs[8]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, 1};
    vecs[9]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, 1};
    vecs[10] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000, 1};
    vecs[11] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 1};
    vecs[12] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 6};
    vecs[13] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0110, 4};

    #12;
    check_eq("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check_eq("rst_result", ifc.result, 32'd0);
    check_eq("rst_flags", {28'd0, flags_now()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_vec(i, (i == 0) ? 3 : 0);
    end

    // Abort a cancellation case while it is left-normalizing.
    @(negedge clk);
    ifc.a        = 32'h3F800001;
    ifc.b        = 32'h3F800000;
    ifc.op       = 1'b1;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    check_eq("abort_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check_eq("abort_result", ifc.result, 32'd0);
    check_eq("abort_flags", {28'd0, flags_now()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ifc.out_valid) saw_valid = 1'b1;
    end
    check_eq("abort_no_stale_valid", {31'd0, saw_valid}, 32'd0);

    run_vec(0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
